multi_counter_sum: RTL

//  N-channel counter bank with a registered sum of all channels and a threshold monitor.

---
 rtl/multi_counter_sum.sv | 96 +++++++++
 1 files changed

// File: rtl/multi_counter_sum.sv
`default_nettype none
// ============================================================================
// Module      : multi_counter_sum
// Description : N-channel counter bank with registered channel sum and a
//               threshold monitor that reloads all channels on trip.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_counter_sum #(
  parameter  int NCH   = 4,
  parameter  int WIDTH = 8,
  parameter  int SAT   = 0,
  localparam int SUM_W = WIDTH + $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic                 load,
  input  logic [NCH*WIDTH-1:0] init_flat,
  input  logic [WIDTH-1:0]     thresh,
  output logic [NCH*WIDTH-1:0] cnt_flat,
  output logic [SUM_W-1:0]     sum,
  output logic                 trip,
  output logic [15:0]          trip_count
);

  localparam logic [WIDTH-1:0] c_cnt_max   = {WIDTH{1'b1}};
  localparam logic [15:0]      c_trip_max  = 16'hFFFF;

  logic             r_trip;
  logic             r_trip_d;
  logic [15:0]      r_trip_count;
  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_thresh_ext;
  logic             w_reload;
  logic             w_trip_rise;

  // Load and trip both select the init value, so asserting both is one reload.
  assign w_reload = load | r_trip;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_inc;

    if (SAT != 0) begin : g_sat
      assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
    end else begin : g_wrap
      assign w_cnt_inc = r_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_reload) begin
        r_cnt <= init_flat[i*WIDTH +: WIDTH];
      end else if (en[i]) begin
        r_cnt <= w_cnt_inc;
      end
    end

    assign cnt_flat[i*WIDTH +: WIDTH] = r_cnt;
  end

  // Every channel is zero-extended before accumulation, so the sum never wraps.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NCH; k++) begin
      w_sum = w_sum + SUM_W'(cnt_flat[k*WIDTH +: WIDTH]);
    end
  end

  assign w_thresh_ext = SUM_W'(thresh);
  assign w_trip_rise  = r_trip & ~r_trip_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum        <= '0;
      r_trip       <= 1'b0;
      r_trip_d     <= 1'b0;
      r_trip_count <= '0;
    end else begin
      r_sum    <= w_sum;
      r_trip   <= (r_sum > w_thresh_ext);
      r_trip_d <= r_trip;
      if (w_trip_rise && (r_trip_count != c_trip_max)) begin
        r_trip_count <= r_trip_count + 16'd1;
      end
    end
  end

  assign sum        = r_sum;
  assign trip       = r_trip;
  assign trip_count = r_trip_count;

endmodule
`default_nettype wire
